// File: rtl/tl_memory_if.sv
// EX/MEM -> MEM/WB bundle for the MIPS MEM stage (tl_memory).
// The master is the EX-side driver and WB-side consumer; the slave is the MEM stage.
interface tl_memory_if #(
   parameter int len    = 32,
   parameter int NB_REG = 5
);
   logic              i_valid;
   logic [len-1:0]    i_alu_result;
   logic [len-1:0]    i_dato2;
   logic              i_mem_read;
   logic              i_mem_write;
   logic [1:0]        i_mem_size;
   logic              i_mem_unsigned;
   logic              i_mem_to_reg;
   logic              i_reg_write;
   logic [NB_REG-1:0] i_rd;

   logic [len-1:0]    o_read_data;
   logic [len-1:0]    o_alu_result;
   logic              o_mem_to_reg;
   logic              o_reg_write;
   logic [NB_REG-1:0] o_rd;
   logic              o_valid;
   logic              o_misaligned;
   logic              o_fault_sticky;

   modport master (
      output i_valid, i_alu_result, i_dato2, i_mem_read, i_mem_write,
             i_mem_size, i_mem_unsigned, i_mem_to_reg, i_reg_write, i_rd,
      input  o_read_data, o_alu_result, o_mem_to_reg, o_reg_write, o_rd,
             o_valid, o_misaligned, o_fault_sticky
   );

   modport slave (
      input  i_valid, i_alu_result, i_dato2, i_mem_read, i_mem_write,
             i_mem_size, i_mem_unsigned, i_mem_to_reg, i_reg_write, i_rd,
      output o_read_data, o_alu_result, o_mem_to_reg, o_reg_write, o_rd,
             o_valid, o_misaligned, o_fault_sticky
   );
endinterface

// File: rtl/tl_memory.sv
// MIPS MEM stage: byte/half/word load-store into internal data memory, drives MEM/WB.
// Optional MEM_DEBUG_PORT_EN adds a combinational debug read port (i_debug_addr/o_debug_data).
module tl_memory #(
   parameter int len     = 32,
   parameter int NB_ADDR = 7,
   parameter int NB_REG  = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   tl_memory_if.slave         bus
`ifdef MEM_DEBUG_PORT_EN
   ,
   input  logic [NB_ADDR-1:0] i_debug_addr,
   output logic [len-1:0]     o_debug_data
`endif
);

   localparam int DEPTH = 2 ** NB_ADDR;

   logic [len-1:0]     mem_q [0:DEPTH-1];

   logic [len-1:0]     read_data_q,    read_data_d;
   logic [len-1:0]     alu_result_q,   alu_result_d;
   logic               mem_to_reg_q,   mem_to_reg_d;
   logic               reg_write_q,    reg_write_d;
   logic [NB_REG-1:0]  rd_q,           rd_d;
   logic               valid_q,        valid_d;
   logic               misaligned_q,   misaligned_d;
   logic               fault_sticky_q, fault_sticky_d;

   logic [NB_ADDR-1:0] word_idx_s;
   logic [1:0]         lane_s;
   logic [len-1:0]     rd_word_s;
   logic               misaligned_s;
   logic               fault_s;
   logic               store_s;
   logic               load_s;
   logic [3:0]         byte_en_s;
   logic [len-1:0]     byte_mask_s;
   logic [len-1:0]     store_repl_s;
   logic [len-1:0]     mem_wdata_s;
   logic               mem_we_s;
   logic [len-1:0]     load_ext_s;
   logic               unused_addr_s;

   function automatic logic [len-1:0] load_extend(input logic [len-1:0] word,
                                                  input logic [1:0]     lane,
                                                  input logic [1:0]     size,
                                                  input logic           uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [len-1:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         2'b00:   r = uns ? {{(len-8){1'b0}}, b} : {{(len-8){b[7]}}, b};
         2'b01:   r = uns ? {{(len-16){1'b0}}, h} : {{(len-16){h[15]}}, h};
         2'b10:   r = word;
         default: r = '0;
      endcase
      return r;
   endfunction

   assign word_idx_s    = bus.i_alu_result[NB_ADDR+1:2];
   assign lane_s        = bus.i_alu_result[1:0];
   assign rd_word_s     = mem_q[word_idx_s];
   assign unused_addr_s = ^bus.i_alu_result[len-1:NB_ADDR+2];

   // Address decode: alignment check, lane enables and merged store word
   always_comb begin
      misaligned_s = 1'b0;
      byte_en_s    = 4'b0000;
      store_repl_s = bus.i_dato2;
      case (bus.i_mem_size)
         2'b00: begin
            misaligned_s = 1'b0;
            byte_en_s    = 4'b0001 << lane_s;
            store_repl_s = {4{bus.i_dato2[7:0]}};
         end
         2'b01: begin
            misaligned_s = lane_s[0];
            byte_en_s    = lane_s[1] ? 4'b1100 : 4'b0011;
            store_repl_s = {2{bus.i_dato2[15:0]}};
         end
         2'b10: begin
            misaligned_s = (lane_s != 2'b00);
            byte_en_s    = 4'b1111;
            store_repl_s = bus.i_dato2;
         end
         default: begin
            misaligned_s = 1'b1;
            byte_en_s    = 4'b0000;
            store_repl_s = bus.i_dato2;
         end
      endcase
      byte_mask_s = {{8{byte_en_s[3]}}, {8{byte_en_s[2]}}, {8{byte_en_s[1]}}, {8{byte_en_s[0]}}};
      mem_wdata_s = (store_repl_s & byte_mask_s) | (rd_word_s & ~byte_mask_s);
   end

   // Qualify access, build next MEM/WB register contents
   always_comb begin
      fault_s    = bus.i_valid & (bus.i_mem_read | bus.i_mem_write) & misaligned_s;
      store_s    = bus.i_valid & bus.i_mem_write & ~fault_s;
      load_s     = bus.i_valid & bus.i_mem_read & ~bus.i_mem_write & ~fault_s;
      mem_we_s   = store_s & i_rst;
      load_ext_s = load_extend(rd_word_s, lane_s, bus.i_mem_size, bus.i_mem_unsigned);

      if (load_s) begin
         read_data_d = load_ext_s;
      end else begin
         read_data_d = '0;
      end
      alu_result_d   = bus.i_alu_result;
      mem_to_reg_d   = bus.i_valid & bus.i_mem_to_reg;
      reg_write_d    = bus.i_valid & bus.i_reg_write & ~fault_s;
      rd_d           = bus.i_rd;
      valid_d        = bus.i_valid;
      misaligned_d   = fault_s;
      fault_sticky_d = fault_sticky_q | fault_s;
   end

   // MEM/WB pipeline register, falling edge, synchronous active-low reset
   always_ff @(negedge i_clk) begin
      if (!i_rst) begin
         read_data_q    <= '0;
         alu_result_q   <= '0;
         mem_to_reg_q   <= 1'b0;
         reg_write_q    <= 1'b0;
         rd_q           <= '0;
         valid_q        <= 1'b0;
         misaligned_q   <= 1'b0;
         fault_sticky_q <= 1'b0;
      end else begin
         read_data_q    <= read_data_d;
         alu_result_q   <= alu_result_d;
         mem_to_reg_q   <= mem_to_reg_d;
         reg_write_q    <= reg_write_d;
         rd_q           <= rd_d;
         valid_q        <= valid_d;
         misaligned_q   <= misaligned_d;
         fault_sticky_q <= fault_sticky_d;
      end
   end

   // Data memory write; contents survive reset
   always_ff @(negedge i_clk) begin
      if (mem_we_s) begin
         mem_q[word_idx_s] <= mem_wdata_s;
      end
   end

   assign bus.o_read_data    = read_data_q;
   assign bus.o_alu_result   = alu_result_q;
   assign bus.o_mem_to_reg   = mem_to_reg_q;
   assign bus.o_reg_write    = reg_write_q;
   assign bus.o_rd           = rd_q;
   assign bus.o_valid        = valid_q;
   assign bus.o_misaligned   = misaligned_q;
   assign bus.o_fault_sticky = fault_sticky_q;

`ifdef MEM_DEBUG_PORT_EN
   assign o_debug_data = mem_q[i_debug_addr];
`endif

endmodule

// File: tb/tb_tl_memory.sv
// Directed self-checking bench for tl_memory (falling-edge MEM stage).
module tb_tl_memory;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   tl_memory_if #(.len(32), .NB_REG(5)) bus ();

`ifdef MEM_DEBUG_PORT_EN
   logic [6:0]  dbg_addr;
   logic [31:0] dbg_data;
`endif

   tl_memory #(.len(32), .NB_ADDR(7), .NB_REG(5)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
`ifdef MEM_DEBUG_PORT_EN
      ,
      .i_debug_addr (dbg_addr),
      .o_debug_data (dbg_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one EX/MEM slot, let it cross the falling edge, return 1 time unit later
   task automatic op(input logic v, input logic [31:0] addr, input logic [31:0] data,
                     input logic rd_en, input logic wr_en, input logic [1:0] size,
                     input logic uns, input logic m2r, input logic rw, input logic [4:0] rd);
      bus.i_valid        = v;
      bus.i_alu_result   = addr;
      bus.i_dato2        = data;
      bus.i_mem_read     = rd_en;
      bus.i_mem_write    = wr_en;
      bus.i_mem_size     = size;
      bus.i_mem_unsigned = uns;
      bus.i_mem_to_reg   = m2r;
      bus.i_reg_write    = rw;
      bus.i_rd           = rd;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      op(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd7);
      op(1'b1, 32'h0000_0044, 32'h1111_2222, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd7);
      n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.o_valid); end
      n_tests++; if (bus.o_reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_reg_write: got %b exp 0", bus.o_reg_write); end
      n_tests++; if (bus.o_alu_result !== 32'h0) begin n_fail++; $display("FAIL rst_alu_result: got %h exp 0", bus.o_alu_result); end
      n_tests++; if (bus.o_rd !== 5'd0 || bus.o_mem_to_reg !== 1'b0 || bus.o_read_data !== 32'h0)
         begin n_fail++; $display("FAIL rst_misc: rd %h m2r %b data %h exp all 0", bus.o_rd, bus.o_mem_to_reg, bus.o_read_data); end
      n_tests++; if (bus.o_fault_sticky !== 1'b0 || bus.o_misaligned !== 1'b0)
         begin n_fail++; $display("FAIL rst_fault: sticky %b mis %b exp 0 0", bus.o_fault_sticky, bus.o_misaligned); end
      rst = 1'b1;
   endtask

   task automatic test_word;
      op(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
      n_tests++; if (bus.o_read_data !== 32'h0 || bus.o_misaligned !== 1'b0)
         begin n_fail++; $display("FAIL sw_outputs: data %h mis %b exp 0 0", bus.o_read_data, bus.o_misaligned); end
      op(1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd5);
      n_tests++; if (bus.o_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_word: got %h exp deadbeef", bus.o_read_data); end
      n_tests++; if (bus.o_reg_write !== 1'b1 || bus.o_mem_to_reg !== 1'b1 || bus.o_rd !== 5'd5 || bus.o_valid !== 1'b1)
         begin n_fail++; $display("FAIL lw_ctrl: rw %b m2r %b rd %0d v %b exp 1 1 5 1", bus.o_reg_write, bus.o_mem_to_reg, bus.o_rd, bus.o_valid); end
      n_tests++; if (bus.o_alu_result !== 32'h10) begin n_fail++; $display("FAIL lw_alu: got %h exp 10", bus.o_alu_result); end
   endtask

   task automatic test_byte;
      op(1'b1, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
      op(1'b1, 32'h0000_0013, 32'h1234_5680, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
      op(1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 5'd2);
      n_tests++; if (bus.o_read_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb: got %h exp ffffff80", bus.o_read_data); end
      op(1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 5'd2);
      n_tests++; if (bus.o_read_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu: got %h exp 00000080", bus.o_read_data); end
      op(1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd2);
      n_tests++; if (bus.o_read_data !== 32'h8000_0000) begin n_fail++; $display("FAIL lw_after_sb: got %h exp 80000000", bus.o_read_data); end
   endtask

   task automatic test_half;
      op(1'b1, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
      op(1'b1, 32'h0000_0022, 32'hABCD_1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0);
      op(1'b1, 32'h0000_0022, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 5'd3);
      n_tests++; if (bus.o_read_data !== 32'h0000_1234) begin n_fail++; $display("FAIL lh_pos: got %h exp 00001234", bus.o_read_data); end
      op(1'b1, 32'h0000_0022, 32'h0000_8001, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0);
      op(1'b1, 32'h0000_0022, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 5'd3);
      n_tests++; if (bus.o_read_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_neg: got %h exp ffff8001", bus.o_read_data); end
      op(1'b1, 32'h0000_0022, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd3);
      n_tests++; if (bus.o_read_data !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu: got %h exp 00008001", bus.o_read_data); end
      op(1'b1, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd3);
      n_tests++; if (bus.o_read_data !== 32'h8001_0000) begin n_fail++; $display("FAIL lw_after_sh: got %h exp 80010000", bus.o_read_data); end
   endtask

   task automatic test_fault;
      op(1'b1, 32'h0000_0002, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd4);
      n_tests++; if (bus.o_misaligned !== 1'b1 || bus.o_fault_sticky !== 1'b1)
         begin n_fail++; $display("FAIL lw_mis_flags: mis %b sticky %b exp 1 1", bus.o_misaligned, bus.o_fault_sticky); end
      n_tests++; if (bus.o_reg_write !== 1'b0 || bus.o_read_data !== 32'h0)
         begin n_fail++; $display("FAIL lw_mis_kill: rw %b data %h exp 0 0", bus.o_reg_write, bus.o_read_data); end
      op(1'b1, 32'h0000_0023, 32'h0000_FFFF, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0);
      n_tests++; if (bus.o_misaligned !== 1'b1) begin n_fail++; $display("FAIL sh_mis: got %b exp 1", bus.o_misaligned); end
      op(1'b1, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd4);
      n_tests++; if (bus.o_read_data !== 32'h8001_0000 || bus.o_misaligned !== 1'b0 || bus.o_fault_sticky !== 1'b1)
         begin n_fail++; $display("FAIL after_fault: data %h mis %b sticky %b exp 80010000 0 1", bus.o_read_data, bus.o_misaligned, bus.o_fault_sticky); end
      op(1'b1, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 5'd4);
      n_tests++; if (bus.o_misaligned !== 1'b1 || bus.o_reg_write !== 1'b0)
         begin n_fail++; $display("FAIL size11: mis %b rw %b exp 1 0", bus.o_misaligned, bus.o_reg_write); end
      op(1'b1, 32'h0000_0002, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd9);
      n_tests++; if (bus.o_misaligned !== 1'b0 || bus.o_reg_write !== 1'b1 || bus.o_read_data !== 32'h0 || bus.o_alu_result !== 32'h2)
         begin n_fail++; $display("FAIL alu_op: mis %b rw %b data %h alu %h exp 0 1 0 2", bus.o_misaligned, bus.o_reg_write, bus.o_read_data, bus.o_alu_result); end
      rst = 1'b0;
      op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
      rst = 1'b1;
      n_tests++; if (bus.o_fault_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b exp 0", bus.o_fault_sticky); end
   endtask

   task automatic test_suppress;
      op(1'b1, 32'h0000_0040, 32'h1122_3344, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
      op(1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd6);
      n_tests++; if (bus.o_reg_write !== 1'b0 || bus.o_mem_to_reg !== 1'b0 || bus.o_valid !== 1'b0)
         begin n_fail++; $display("FAIL bubble_ctrl: rw %b m2r %b v %b exp 0 0 0", bus.o_reg_write, bus.o_mem_to_reg, bus.o_valid); end
      op(1'b1, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd6);
      n_tests++; if (bus.o_read_data !== 32'h1122_3344) begin n_fail++; $display("FAIL bubble_store: got %h exp 11223344", bus.o_read_data); end
      rst = 1'b0;
      op(1'b1, 32'h0000_0040, 32'h5555_5555, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
      rst = 1'b1;
      op(1'b1, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd6);
      n_tests++; if (bus.o_read_data !== 32'h1122_3344) begin n_fail++; $display("FAIL reset_store: got %h exp 11223344", bus.o_read_data); end
      op(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd6);
      n_tests++; if (bus.o_read_data !== 32'h0) begin n_fail++; $display("FAIL rw_both_data: got %h exp 0", bus.o_read_data); end
      op(1'b1, 32'h0000_0044, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd6);
      n_tests++; if (bus.o_read_data !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL rw_both_store: got %h exp 0badcafe", bus.o_read_data); end
   endtask

   task automatic test_wrap;
      op(1'b1, 32'h0000_0200, 32'h5A5A_5A5A, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
      op(1'b1, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd8);
      n_tests++; if (bus.o_read_data !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL wrap: got %h exp 5a5a5a5a", bus.o_read_data); end
`ifdef MEM_DEBUG_PORT_EN
      dbg_addr = 7'd0;
      #1;
      n_tests++; if (dbg_data !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL debug_port: got %h exp 5a5a5a5a", dbg_data); end
      dbg_addr = 7'h10;
      #1;
      n_tests++; if (dbg_data !== 32'h1122_3344) begin n_fail++; $display("FAIL debug_port_40: got %h exp 11223344", dbg_data); end
`endif
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
`ifdef MEM_DEBUG_PORT_EN
      dbg_addr = 7'd0;
`endif
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_fault();
      test_suppress();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
